// File: rtl/mac_sched.sv
// ---------------------------------------------------------------------------
// mac_sched
// Round-robin scheduler that shares one multiply-accumulate datapath between
// NREQ requesters. A granted requester gets a burst of len[i] MAC strobes.
// Each requester is served at most once per 32 kHz frame. Frame-budget
// violations are recorded in a sticky overrun flag.
//
// Ports
//   clk240m   : system clock, rising edge
//   reset     : asynchronous active-high reset
//   en32k     : one-cycle frame-start strobe; clears the per-frame served set
//   req       : per-requester level request, held until its done pulse
//   len       : per-requester burst length, requester i at [i*LENW +: LENW]
//   ovr_clr   : clears overrun (a simultaneous set wins)
//   gnt       : one-hot grant, held from grant through the done cycle
//   mac_en    : MAC operand-valid strobe, one per tap
//   mac_first : first tap of a burst (the accumulator clears)
//   mac_last  : final tap of a burst
//   done      : one-hot, one-cycle burst-complete pulse
//   overrun   : sticky frame-budget violation flag
// ---------------------------------------------------------------------------
module mac_sched #(
    parameter int NREQ = 4,
    parameter int LENW = 7
) (
    input  logic                   clk240m,
    input  logic                   reset,
    input  logic                   en32k,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LENW-1:0]   len,
    input  logic                   ovr_clr,
    output logic [NREQ-1:0]        gnt,
    output logic                   mac_en,
    output logic                   mac_first,
    output logic                   mac_last,
    output logic [NREQ-1:0]        done,
    output logic                   overrun
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   served_q, served_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_first_q, mac_first_d;
    logic              mac_last_q, mac_last_d;
    logic              overrun_q, overrun_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [LENW-1:0]   cnt_q, cnt_d;

    // Round-robin search: first eligible requester at or above ptr, wrapping.
    logic [NREQ-1:0]   elig;
    logic              found;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     idx_w;
    logic [LENW-1:0]   pick_len;
    int                idx;

    always_comb begin
        elig     = req & ~served_q;
        found    = 1'b0;
        pick     = '0;
        idx      = 0;
        idx_w    = '0;
        pick_len = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = PW'(idx);
            if (!found && elig[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (pick == PW'(k)) begin
                pick_len = len[k*LENW +: LENW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        served_d    = served_q;
        mac_en_d    = 1'b0;
        mac_first_d = 1'b0;
        mac_last_d  = 1'b0;
        overrun_d   = overrun_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    gnt_d = NREQ'(1) << pick;
                    win_d = pick;
                    // Length is latched here; later len changes are ignored.
                    cnt_d = pick_len;
                    if (pick_len != '0) begin
                        state_d     = S_RUN;
                        mac_en_d    = 1'b1;
                        mac_first_d = 1'b1;
                        mac_last_d  = (pick_len == LENW'(1));
                    end else begin
                        // Zero-length burst: done is raised alongside gnt.
                        state_d = S_DONE;
                        done_d  = NREQ'(1) << pick;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LENW'(1)) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end else begin
                    mac_en_d   = 1'b1;
                    mac_last_d = (cnt_q == LENW'(2));
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                served_d = served_q | gnt_q;
                ptr_d    = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Frame start wins over a served bit being set in the same cycle.
        if (en32k) begin
            served_d = '0;
        end

        if (en32k && ((state_q != S_IDLE) || (elig != '0))) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk240m or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            served_q    <= '0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            served_q    <= served_d;
            mac_en_q    <= mac_en_d;
            mac_first_q <= mac_first_d;
            mac_last_q  <= mac_last_d;
            overrun_q   <= overrun_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_mac_sched
// Directed bench for mac_sched. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_mac_sched;

    localparam int NREQ = 4;
    localparam int LENW = 7;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en32k;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] len;
    logic                 ovr_clr;
    logic [NREQ-1:0]      gnt;
    logic                 mac_en;
    logic                 mac_first;
    logic                 mac_last;
    logic [NREQ-1:0]      done;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
        .clk240m   (clk),
        .reset     (reset),
        .en32k     (en32k),
        .req       (req),
        .len       (len),
        .ovr_clr   (ovr_clr),
        .gnt       (gnt),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .done      (done),
        .overrun   (overrun)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_len(input int i, input int v);
        len[i*LENW +: LENW] = LENW'(v);
    endtask

    task automatic test_reset();
        reset = 1'b1; en32k = 1'b0; req = '0; len = '0; ovr_clr = 1'b0;
        repeat (3) tick();
        checks++;
        if ({gnt, mac_en, mac_first, mac_last, done, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {gnt, mac_en, mac_first, mac_last, done, overrun});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL idle_after_reset gnt: got %b expected 0000", gnt);
        end
        $display("test_reset complete");
    endtask

    // Scenario 2: all four requesting, len=2, one frame.
    task automatic test_round_robin();
        logic [NREQ-1:0] ord [8];
        logic [NREQ-1:0] last_g;
        int n, nmac, ndone;
        n = 0; nmac = 0; ndone = 0; last_g = '0;
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gnt !== 4'b0000 && gnt !== last_g && n < 8) begin
                ord[n] = gnt; n++;
            end
            last_g = gnt;
            if (mac_en === 1'b1) nmac++;
            if (done !== 4'b0000) ndone++;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL rr_grant_count: got %0d expected 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ord[i] !== (4'b0001 << i)) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %b expected %b", i, ord[i], 4'b0001 << i);
                end
            end
        end
        checks++;
        if (nmac !== 8) begin
            errors++; $display("FAIL rr_mac_count: got %0d expected 8", nmac);
        end
        checks++;
        if (ndone !== 4) begin
            errors++; $display("FAIL rr_done_count: got %0d expected 4", ndone);
        end
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL rr_no_regrant: got %b expected 0000", gnt);
        end
        // New frame: everyone already served, so no overrun; served clears.
        en32k = 1'b1; tick(); en32k = 1'b0;
        checks++;
        if (overrun !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL rr_frame_start: got ovr=%b gnt=%b expected ovr=0 gnt=0000", overrun, gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL rr_new_frame_grant: got %b expected 0001", gnt);
        end
        // Dropping req while granted must not cut the burst short.
        req = 4'b0000;
        tick();
        checks++;
        if (mac_en !== 1'b1 || mac_last !== 1'b1 || gnt !== 4'b0001) begin
            errors++; $display("FAIL rr_req_drop: got en=%b last=%b gnt=%b expected en=1 last=1 gnt=0001", mac_en, mac_last, gnt);
        end
        tick();
        checks++;
        if (done !== 4'b0001) begin
            errors++; $display("FAIL rr_req_drop_done: got %b expected 0001", done);
        end
        tick();
        $display("test_round_robin complete");
    endtask

    // Scenario 1: single len=3 burst on requester 0.
    task automatic test_single_burst();
        en32k = 1'b1; tick(); en32k = 1'b0;
        set_len(0, 3);
        req = 4'b0001;
        tick();
        checks++;
        if ({gnt, mac_en, mac_first, mac_last, done} !== {4'b0001, 3'b110, 4'b0000}) begin
            errors++; $display("FAIL single_t1: got %b expected 0001_110_0000", {gnt, mac_en, mac_first, mac_last, done});
        end
        tick();
        checks++;
        if ({gnt, mac_en, mac_first, mac_last, done} !== {4'b0001, 3'b100, 4'b0000}) begin
            errors++; $display("FAIL single_t2: got %b expected 0001_100_0000", {gnt, mac_en, mac_first, mac_last, done});
        end
        tick();
        checks++;
        if ({gnt, mac_en, mac_first, mac_last, done} !== {4'b0001, 3'b101, 4'b0000}) begin
            errors++; $display("FAIL single_t3: got %b expected 0001_101_0000", {gnt, mac_en, mac_first, mac_last, done});
        end
        tick();
        checks++;
        if ({gnt, mac_en, mac_first, mac_last, done} !== {4'b0001, 3'b000, 4'b0001}) begin
            errors++; $display("FAIL single_t4: got %b expected 0001_000_0001", {gnt, mac_en, mac_first, mac_last, done});
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, done} !== 8'h00) begin
            errors++; $display("FAIL single_t5: got gnt=%b done=%b expected 0000 0000", gnt, done);
        end
        $display("test_single_burst complete");
    endtask

    // Scenario 3: zero-length burst on requester 2.
    task automatic test_zero_len();
        set_len(2, 0);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || done !== 4'b0100 || mac_en !== 1'b0) begin
            errors++; $display("FAIL zero_len: got gnt=%b done=%b en=%b expected 0100 0100 0", gnt, done, mac_en);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || mac_en !== 1'b0) begin
            errors++; $display("FAIL zero_len_end: got gnt=%b done=%b en=%b expected 0000 0000 0", gnt, done, mac_en);
        end
        $display("test_zero_len complete");
    endtask

    // Scenario 6: frame start on requester 1's done cycle.
    task automatic test_frame_on_done();
        set_len(1, 1);
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, mac_en, mac_first, mac_last} !== {4'b0010, 3'b111}) begin
            errors++; $display("FAIL fod_len1: got %b expected 0010_111", {gnt, mac_en, mac_first, mac_last});
        end
        tick();
        checks++;
        if (done !== 4'b0010) begin
            errors++; $display("FAIL fod_done: got %b expected 0010", done);
        end
        en32k = 1'b1; tick(); en32k = 1'b0;
        checks++;
        if (overrun !== 1'b1 || gnt !== 4'b0000) begin
            errors++; $display("FAIL fod_overrun: got ovr=%b gnt=%b expected 1 0000", overrun, gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL fod_regrant: got %b expected 0010", gnt);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (done !== 4'b0010) begin
            errors++; $display("FAIL fod_redone: got %b expected 0010", done);
        end
        tick();
        $display("test_frame_on_done complete");
    endtask

    // ovr_clr together with a set condition, then ovr_clr alone.
    task automatic test_overrun_clear();
        set_len(3, 2);
        req = 4'b1000;
        en32k = 1'b1; ovr_clr = 1'b1;
        tick();
        en32k = 1'b0; ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1 || gnt !== 4'b1000) begin
            errors++; $display("FAIL ovr_set_wins: got ovr=%b gnt=%b expected 1 1000", overrun, gnt);
        end
        req = 4'b0000;
        repeat (3) tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL ovr_burst_end: got %b expected 0000", gnt);
        end
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        $display("test_overrun_clear complete");
    endtask

    // Scenario 4: len=100 burst crossing a frame boundary.
    task automatic test_long_burst();
        int nmac, nfirst, nlast, ndone;
        bit ended;
        nmac = 0; nfirst = 0; nlast = 0; ndone = 0; ended = 1'b0;
        set_len(0, 100);
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL long_grant: got %b expected 0001", gnt);
        end
        nmac += int'(mac_en); nfirst += int'(mac_first); nlast += int'(mac_last);
        req = 4'b0000;
        set_len(0, 5);
        for (int c = 0; c < 20; c++) begin
            if (c == 19) en32k = 1'b1;
            tick();
            en32k = 1'b0;
            nmac += int'(mac_en); nfirst += int'(mac_first); nlast += int'(mac_last);
            if (done !== 4'b0000) ndone++;
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL long_overrun: got %b expected 1", overrun);
        end
        for (int c = 0; c < 200 && !ended; c++) begin
            tick();
            nmac += int'(mac_en); nfirst += int'(mac_first); nlast += int'(mac_last);
            if (done === 4'b0001) ndone++;
            else if (done !== 4'b0000) ndone += 100;
            if (gnt === 4'b0000) ended = 1'b1;
        end
        checks++;
        if (!ended) begin
            errors++; $display("FAIL long_timeout: got gnt=%b expected 0000 within 200 cycles", gnt);
        end
        checks++;
        if (nmac !== 100 || nfirst !== 1 || nlast !== 1 || ndone !== 1) begin
            errors++; $display("FAIL long_counts: got mac=%0d first=%0d last=%0d done=%0d expected 100 1 1 1", nmac, nfirst, nlast, ndone);
        end
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL long_ovr_clr: got %b expected 0", overrun);
        end
        $display("test_long_burst complete");
    endtask

    // Scenario 5: reset in cycle 5 of a len=10 burst.
    task automatic test_reset_mid_burst();
        set_len(2, 10);
        req = 4'b0100;
        repeat (5) tick();
        checks++;
        if (gnt !== 4'b0100 || mac_en !== 1'b1) begin
            errors++; $display("FAIL rmb_running: got gnt=%b en=%b expected 0100 1", gnt, mac_en);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({gnt, mac_en, mac_first, mac_last, done, overrun} !== '0) begin
            errors++; $display("FAIL rmb_async_clear: got %h expected 0", {gnt, mac_en, mac_first, mac_last, done, overrun});
        end
        req = 4'b0000;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (done !== 4'b0000 || gnt !== 4'b0000) begin
            errors++; $display("FAIL rmb_no_done: got done=%b gnt=%b expected 0000 0000", done, gnt);
        end
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL rmb_first_grant: got %b expected 0001", gnt);
        end
        req = 4'b0000;
        repeat (2) tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL rmb_end: got %b expected 0000", gnt);
        end
        $display("test_reset_mid_burst complete");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_burst();
        test_zero_len();
        test_frame_on_done();
        test_overrun_clear();
        test_long_burst();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the single multiply-accumulate datapath.
REQ-002 Parameter LENW, default 7, width of each requester's burst-length field.
REQ-003 clk240m  input  1  system clock, 240 MHz; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; driven by the synchronized CRU reset.
REQ-005 en32k  input  1  one-cycle frame-start strobe at 32 kHz.
REQ-006 req  input  NREQ  per-requester level request; held until its done pulse.
REQ-007 len  input  NREQ*LENW  per-requester burst length; requester i occupies bits [i*LENW +: LENW].
REQ-008 ovr_clr  input  1  clears the sticky overrun flag.
REQ-009 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-010 mac_en  output  1  MAC operand-valid strobe, one per tap.
REQ-011 mac_first  output  1  marks the first mac_en of a burst; the accumulator clears.
REQ-012 mac_last  output  1  marks the final mac_en of a burst.
REQ-013 done  output  NREQ  one-hot, one-cycle burst-complete pulse.
REQ-014 overrun  output  1  sticky frame-budget violation flag.

Function
REQ-015 The FSM SHALL have three states:
- IDLE: no grant.
- RUN: the MAC burst is in progress.
- DONE: the done pulse is issued.
REQ-016 In IDLE, the eligible set SHALL be req & ~served. If the eligible set is nonzero, the block SHALL pick a winner and assert gnt for it on the next cycle.
REQ-017 Arbitration SHALL be round-robin. The search starts at pointer ptr and proceeds upward with wrap-around from NREQ-1 to 0.
REQ-018 At grant, the winner's len value SHALL be captured into a LENW-bit down-counter. Later changes to len SHALL have no effect on the active burst.
REQ-019 Transition on grant:
- captured len nonzero: the FSM SHALL enter RUN.
- captured len zero: the FSM SHALL enter DONE directly, and no mac_en is issued.
REQ-020 In RUN, mac_en SHALL be 1 on every cycle, and the counter SHALL decrement each cycle. mac_first SHALL be 1 on the first RUN cycle only; mac_last SHALL be 1 on the RUN cycle where the counter equals 1. After that cycle the FSM SHALL enter DONE.
REQ-021 In DONE, the following SHALL occur in one cycle, after which the FSM returns to IDLE:
- done[winner] pulses for that one cycle while gnt is still held.
- served[winner] is set.
- ptr becomes (winner+1) mod NREQ.
REQ-022 gnt SHALL remain constant from the grant cycle through the DONE cycle inclusive, and SHALL be zero in IDLE.
REQ-023 Timing for a request asserted in IDLE at cycle t with len=L>0:
- gnt rises at t+1.
- mac_en is high on cycles t+1..t+L.
- done pulses at t+L+1.
- gnt falls at t+L+2.
- The next grant cannot occur before t+L+3.
REQ-024 Each requester SHALL be served at most once per frame. en32k SHALL clear served to all zero.
REQ-025 When en32k coincides with the DONE cycle, the clear SHALL take precedence: the served bit being set in that cycle is discarded.
REQ-026 When en32k arrives, overrun SHALL be set if the FSM is not in IDLE, or if (req & ~served) is nonzero.
REQ-027 en32k SHALL NOT abort an active burst; the burst completes normally.
REQ-028 ovr_clr SHALL clear overrun. If a set condition occurs in the same cycle, set SHALL win.
REQ-029 A requester deasserting req while granted SHALL NOT terminate the burst.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset is high, the block SHALL hold the following values:
- FSM in IDLE.
- gnt, done, mac_en, mac_first, mac_last and overrun = 0.
- ptr = 0.
- served = 0.
- counter = 0.
REQ-032 Reset asserted mid-burst SHALL drop all outputs asynchronously. No done is issued for the aborted burst.
REQ-033 After reset deasserts, the first arbitration SHALL start from requester 0.

Verification
REQ-034 The testbench SHALL cover the following scenarios:
- Scenario 1: req=0001, len0=3 at t -> gnt=0001 at t+1; mac_en at t+1..t+3; mac_first at t+1; mac_last at t+3; done=0001 at t+4; gnt=0 at t+5.
- Scenario 2: req=1111 held, all len=2, one frame -> gnt order 0,1,2,3. Each requester is served once, there are no further grants until en32k, and served is cleared at en32k.
- Scenario 3: len2=0, req=0100 -> gnt=0100 and done=0100 in the same cycle t+1, with no mac_en.
- Scenario 4: burst with len=100 started 20 cycles before en32k -> overrun=1 after en32k; the burst still completes with 100 mac_en; ovr_clr then clears overrun.
- Scenario 5: reset pulsed at cycle 5 of a len=10 burst -> all outputs 0 immediately, no done, and the next grant goes to requester 0.
- Scenario 6: en32k in the DONE cycle of requester 1, with req1 still high -> requester 1 is eligible again in the new frame.
